// File: rtl/sample_feeder_if.sv
// Host-load and neuron-serve signal bundle for sample_feeder.
// The slave modport is the feeder; the master modport is the host/neuron side.
interface sample_feeder_if #(
  parameter int X_W = 7,
  parameter int T_W = 2
);
  logic           clear;
  logic           wr_en;
  logic [X_W-1:0] wr_x1;
  logic [X_W-1:0] wr_x2;
  logic [T_W-1:0] wr_t;
  logic           request;
  logic           stop;
  logic [31:0]    n_out;
  logic [X_W-1:0] x1_out;
  logic [X_W-1:0] x2_out;
  logic [T_W-1:0] t_out;
  logic           data_ready;
  logic           epoch_wrap;
  logic [15:0]    epochs;
  logic           full;
  logic           empty;
  logic           overflow;

  modport master (
    output clear, wr_en, wr_x1, wr_x2, wr_t, request, stop,
    input  n_out, x1_out, x2_out, t_out, data_ready, epoch_wrap, epochs,
           full, empty, overflow
  );

  modport slave (
    input  clear, wr_en, wr_x1, wr_x2, wr_t, request, stop,
    output n_out, x1_out, x2_out, t_out, data_ready, epoch_wrap, epochs,
           full, empty, overflow
  );
endinterface

// File: rtl/sample_feeder.sv
// Training-sample buffer: the host appends (x1, x2, t) samples, and the neuron pulls
// them one request at a time, wrapping around the buffer once per epoch.
//
//   state | meaning
//   IDLE  | waiting for a request rising edge; host writes accepted
//   READ  | buffer word captured, latch it onto the outputs
//   SERVE | sample presented with data_ready until request drops
//   HALT  | neuron signalled stop; serving suspended, outputs frozen
module sample_feeder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int X_W    = 7,
  parameter int T_W    = 2
) (
  input logic             clk,
  input logic             rst,
  sample_feeder_if.slave  bus
);
  localparam int S_W = 2*X_W + T_W;

  typedef enum logic [1:0] {IDLE, READ, SERVE, HALT} state_t;

  state_t            state;
  logic [S_W-1:0]    mem [DEPTH];
  logic [S_W-1:0]    rd_data;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] rd_ptr;
  logic              request_q;
  logic [X_W-1:0]    x1_q;
  logic [X_W-1:0]    x2_q;
  logic [T_W-1:0]    t_q;
  logic              data_ready_q;
  logic              epoch_wrap_q;
  logic [15:0]       epochs_q;
  logic              overflow_q;
  logic              is_full;
  logic              is_empty;
  logic              wr_accept;
  logic              last_entry;

  assign is_full    = (count == (ADDR_W+1)'(DEPTH));
  assign is_empty   = (count == '0);
  assign wr_accept  = bus.wr_en && !is_full && (state == IDLE) && !bus.clear;
  assign last_entry = ({1'b0, rd_ptr} == (count - 1'b1));

  // The read port runs every cycle; READ consumes the word captured while in IDLE.
  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[count[ADDR_W-1:0]] <= {bus.wr_x1, bus.wr_x2, bus.wr_t};
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      request_q    <= 1'b0;
      x1_q         <= '0;
      x2_q         <= '0;
      t_q          <= '0;
      data_ready_q <= 1'b0;
      epoch_wrap_q <= 1'b0;
      epochs_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      request_q    <= bus.request;
      epoch_wrap_q <= 1'b0;
      if (bus.clear) begin
        state        <= IDLE;
        count        <= '0;
        rd_ptr       <= '0;
        epochs_q     <= '0;
        overflow_q   <= 1'b0;
        data_ready_q <= 1'b0;
      end else begin
        if (wr_accept)
          count <= count + 1'b1;
        if (bus.wr_en && is_full)
          overflow_q <= 1'b1;
        if (bus.stop) begin
          state        <= HALT;
          data_ready_q <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              // empty check uses the pre-write count, so a same-cycle write does not count
              if (bus.request && !request_q && !is_empty)
                state <= READ;
            end
            READ: begin
              {x1_q, x2_q, t_q} <= rd_data;
              data_ready_q      <= 1'b1;
              state             <= SERVE;
            end
            SERVE: begin
              if (!bus.request) begin
                data_ready_q <= 1'b0;
                state        <= IDLE;
                if (last_entry) begin
                  rd_ptr       <= '0;
                  epoch_wrap_q <= 1'b1;
                  if (epochs_q != 16'hFFFF)
                    epochs_q <= epochs_q + 16'd1;
                end else begin
                  rd_ptr <= rd_ptr + 1'b1;
                end
              end
            end
            HALT:    state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.n_out      = {{(32-ADDR_W-1){1'b0}}, count};
  assign bus.x1_out     = x1_q;
  assign bus.x2_out     = x2_q;
  assign bus.t_out      = t_q;
  assign bus.data_ready = data_ready_q;
  assign bus.epoch_wrap = epoch_wrap_q;
  assign bus.epochs     = epochs_q;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sample_feeder.sv
// Directed sequence with random sample data, checked against a queue-based model
// of the buffer contents, read index and epoch count.
module tb_sample_feeder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_feeder_if #(.X_W(7), .T_W(2)) bus();
  sample_feeder dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [6:0] qx1[$];
  logic [6:0] qx2[$];
  logic [1:0] qt[$];
  int rd  = 0;
  int ep  = 0;
  bit ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qx1.delete(); qx2.delete(); qt.delete();
    rd = 0; ep = 0; ovf = 0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_n_out"},    bus.n_out,    qx1.size());
    chk({tag, "_empty"},    bus.empty,    32'(qx1.size() == 0));
    chk({tag, "_full"},     bus.full,     32'(qx1.size() == 64));
    chk({tag, "_overflow"}, bus.overflow, 32'(ovf));
    chk({tag, "_epochs"},   bus.epochs,   ep);
  endtask

  task automatic wr(input logic [6:0] a, input logic [6:0] b, input logic [1:0] t);
    bus.wr_en = 1'b1; bus.wr_x1 = a; bus.wr_x2 = b; bus.wr_t = t;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (qx1.size() < 64) begin
      qx1.push_back(a); qx2.push_back(b); qt.push_back(t);
    end else begin
      ovf = 1;
    end
  endtask

  function automatic logic [1:0] rand_t();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11;
  endfunction

  task automatic rand_wr();
    wr(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), rand_t());
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    model_reset();
  endtask

  // One complete request/serve handshake. simul: write in the request-edge cycle.
  // poke: attempt a write while the sample is being served (must be dropped).
  task automatic serve(input int hold, input bit simul, input bit poke);
    int  n;
    bit  wrap;
    logic [6:0] sa, sb;
    logic [1:0] st;
    n = qx1.size();
    bus.request = 1'b1;
    if (simul) begin
      sa = 7'($urandom_range(0, 127)); sb = 7'($urandom_range(0, 127)); st = rand_t();
      bus.wr_en = 1'b1; bus.wr_x1 = sa; bus.wr_x2 = sb; bus.wr_t = st;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (simul) begin
      qx1.push_back(sa); qx2.push_back(sb); qt.push_back(st);
    end
    chk("dr_latency1", bus.data_ready, 0);
    @(negedge clk);
    chk("dr_latency2", bus.data_ready, 1);
    chk("x1_out", bus.x1_out, qx1[rd]);
    chk("x2_out", bus.x2_out, qx2[rd]);
    chk("t_out",  bus.t_out,  qt[rd]);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 0) begin
        bus.wr_en = 1'b1; bus.wr_x1 = 7'h55; bus.wr_x2 = 7'h2A; bus.wr_t = 2'b01;
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      chk("dr_hold", bus.data_ready, 1);
      chk("x1_hold", bus.x1_out, qx1[rd]);
      chk("n_out_hold", bus.n_out, qx1.size());
    end
    bus.request = 1'b0;
    @(negedge clk);
    chk("dr_drop", bus.data_ready, 0);
    wrap = (rd == n - 1) || (simul && rd == qx1.size() - 1 && 0);
    wrap = (rd == qx1.size() - 1);
    chk("epoch_wrap", bus.epoch_wrap, 32'(wrap));
    if (wrap) begin
      rd = 0;
      if (ep < 65535) ep++;
    end else begin
      rd++;
    end
    chk("epochs", bus.epochs, ep);
    @(negedge clk);
    chk("wrap_pulse_end", bus.epoch_wrap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] held_x1;
    rst = 1'b0;
    bus.clear = 1'b0; bus.wr_en = 1'b0; bus.wr_x1 = '0; bus.wr_x2 = '0; bus.wr_t = '0;
    bus.request = 1'b0; bus.stop = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_dr", bus.data_ready, 0);
    chk("rst_wrap", bus.epoch_wrap, 0);
    chk("rst_x1", bus.x1_out, 0);
    chk("rst_t", bus.t_out, 0);
    chk_status("rst");
    rst = 1'b1;
    @(negedge clk);

    // first sample directed, then random; serve with request held
    wr(7'd3, 7'h7E, 2'b01);
    repeat (3) rand_wr();
    chk_status("load4");
    serve(3, 0, 0);

    // rest of the epoch plus wrap back to sample 0
    repeat (3) serve(0, 0, 0);
    chk("epoch1", bus.epochs, 1);
    serve(1, 0, 0);

    // request against an empty buffer
    do_clear();
    chk_status("clr1");
    bus.request = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("empty_req_dr", bus.data_ready, 0);
    end
    bus.request = 1'b0;
    @(negedge clk);

    // fill to capacity, overflow, full epoch
    repeat (64) rand_wr();
    chk_status("fill64");
    rand_wr();
    chk_status("ovf");
    for (int i = 0; i < 64; i++) serve(0, 0, 0);
    serve(0, 0, 0);
    chk_status("after_full_epoch");
    do_clear();
    chk_status("clr2");

    // writes while serving are dropped; write coincident with request edge is kept
    repeat (3) rand_wr();
    serve(2, 0, 1);
    serve(1, 1, 0);
    chk_status("simul");

    // stop during SERVE
    bus.request = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_stop_dr", bus.data_ready, 1);
    held_x1 = qx1[rd];
    bus.stop = 1'b1;
    @(negedge clk);
    chk("stop_dr", bus.data_ready, 0);
    chk("stop_x1_hold", bus.x1_out, held_x1);
    bus.request = 1'b0;
    @(negedge clk);
    bus.request = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("halt_dr", bus.data_ready, 0);
    end
    bus.request = 1'b0;
    bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    serve(0, 0, 0);

    // async reset while data_ready is high
    bus.request = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_dr", bus.data_ready, 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_dr", bus.data_ready, 0);
    chk("async_rst_x1", bus.x1_out, 0);
    chk("async_rst_x2", bus.x2_out, 0);
    chk_status("async_rst");
    @(negedge clk);
    bus.request = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) rand_wr();
    serve(0, 0, 0);
    serve(0, 0, 0);
    chk_status("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
